// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU calculator: datapath widths, the
// transmit-controller state encoding and a byte-lane helper.
package uart_alu_pkg;

   localparam int unsigned RESULT_W = 16;
   localparam int unsigned BYTE_W   = 8;

   typedef enum logic [3:0] {
      TX_IDLE      = 4'd0,
      TX_START     = 4'd1,
      TX_WAIT_ACK  = 4'd2,
      TX_WAIT_DONE = 4'd3
   } tx_state_e;

   function automatic logic [BYTE_W-1:0] select_byte(input logic [RESULT_W-1:0] value,
                                                     input logic              upper);
      return upper ? value[RESULT_W-1:BYTE_W] : value[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/tx_controller.sv
// Serialises a 16-bit ALU result as two bytes to the UART transmitter using a
// start/busy handshake, with a one-deep pending slot for results arriving mid-send.
module tx_controller
   import uart_alu_pkg::*;
#(
   parameter int unsigned MSB_FIRST   = 0,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                send_result,
   input  logic [RESULT_W-1:0] alu_result,
   input  logic                tx_busy,
   output logic                tx_start,
   output logic [BYTE_W-1:0]   tx_data,
   output logic                tx_active,
   output logic                ack_error
);

   localparam logic       MSB_SEL  = (MSB_FIRST != 0);
   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

   tx_state_e           state_q, state_d;
   logic [RESULT_W-1:0] result_q, result_d;
   logic [RESULT_W-1:0] pending_q, pending_d;
   logic                pending_valid, pending_valid_d;
   logic                byte_idx, byte_idx_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                ack_error_d;
   logic                byte_done;

   always_comb begin
      state_d         = state_q;
      result_d        = result_q;
      pending_d       = pending_q;
      pending_valid_d = pending_valid;
      byte_idx_d      = byte_idx;
      cnt_d           = cnt_q;
      ack_error_d     = ack_error;
      byte_done       = 1'b0;

      if (send_result && (state_q != TX_IDLE || pending_valid)) begin
         pending_d       = alu_result;
         pending_valid_d = 1'b1;
      end

      case (state_q)
         // IDLE shares the end-of-result path so a request launches identically
         // whether it arrives while idle or on the final byte's exit.
         TX_IDLE:      byte_done = 1'b1;
         TX_START: begin
            state_d = TX_WAIT_ACK;
            cnt_d   = '0;
         end
         TX_WAIT_ACK: begin
            if (tx_busy) begin
               state_d = TX_WAIT_DONE;
            end else if (cnt_q == ACK_LAST) begin
               ack_error_d = 1'b1;
               byte_done   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         TX_WAIT_DONE: byte_done = !tx_busy;
         default:      state_d = TX_IDLE;
      endcase

      if (byte_done) begin
         if (state_q != TX_IDLE && !byte_idx) begin
            byte_idx_d = 1'b1;
            state_d    = TX_START;
         end else if (pending_valid) begin
            // A request landing in this same cycle stays pending behind this one.
            result_d        = pending_q;
            pending_valid_d = send_result;
            byte_idx_d      = 1'b0;
            state_d         = TX_START;
         end else if (send_result) begin
            result_d        = alu_result;
            pending_valid_d = 1'b0;
            byte_idx_d      = 1'b0;
            state_d         = TX_START;
         end else begin
            state_d = TX_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= TX_IDLE;
         result_q      <= '0;
         pending_q     <= '0;
         pending_valid <= 1'b0;
         byte_idx      <= 1'b0;
         cnt_q         <= '0;
         ack_error     <= 1'b0;
         tx_start      <= 1'b0;
         tx_data       <= '0;
         tx_active     <= 1'b0;
      end else begin
         state_q       <= state_d;
         result_q      <= result_d;
         pending_q     <= pending_d;
         pending_valid <= pending_valid_d;
         byte_idx      <= byte_idx_d;
         cnt_q         <= cnt_d;
         ack_error     <= ack_error_d;
         tx_start      <= (state_d == TX_START);
         tx_active     <= (state_d != TX_IDLE) || pending_valid_d;
         if (state_d == TX_START) begin
            tx_data <= select_byte(result_d, byte_idx_d ^ MSB_SEL);
         end
      end
   end

endmodule

// File: tb/tb_tx_controller.sv
// Directed bench for tx_controller: LSB-first and MSB-first instances run in
// lockstep against a behavioural UART transmitter busy model.
module tb_tx_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        send_result;
   logic [15:0] alu_result;
   logic        tx_busy = 1'b0;
   logic        tx_start_a, tx_active_a, ack_error_a;
   logic [7:0]  tx_data_a;
   logic        tx_start_b, tx_active_b, ack_error_b;
   logic [7:0]  tx_data_b;

   tx_controller #(.MSB_FIRST(0), .ACK_TIMEOUT(16)) dut_lsb (
      .clk(clk), .reset(reset), .send_result(send_result), .alu_result(alu_result),
      .tx_busy(tx_busy), .tx_start(tx_start_a), .tx_data(tx_data_a),
      .tx_active(tx_active_a), .ack_error(ack_error_a));

   tx_controller #(.MSB_FIRST(1), .ACK_TIMEOUT(16)) dut_msb (
      .clk(clk), .reset(reset), .send_result(send_result), .alu_result(alu_result),
      .tx_busy(tx_busy), .tx_start(tx_start_b), .tx_data(tx_data_b),
      .tx_active(tx_active_b), .ack_error(ack_error_b));

   always #5 clk = ~clk;

   int         n_pass = 0;
   int         n_total = 0;
   int         cyc = 0;
   int         req_edge;
   logic [7:0] log_a[$];
   logic [7:0] log_b[$];
   int         cyc_a[$];
   logic       prev_start_a = 1'b0;
   bit         busy_mode = 1'b0;   // 0: normal transmitter, 1: busy tied low
   bit         arm = 1'b0;
   int         hold = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Busy rises one cycle after tx_start is seen and stays up for 10 sampling edges.
   always @(negedge clk) begin
      if (reset || busy_mode) begin
         tx_busy = 1'b0;
         arm     = 1'b0;
         hold    = 0;
      end else begin
         if (arm) begin
            tx_busy = 1'b1;
            hold    = 10;
            arm     = 1'b0;
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) tx_busy = 1'b0;
         end
         if (tx_start_a) arm = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset && (tx_start_a === 1'b1 || tx_start_b === 1'b1)) begin
         check("start_sync_b", tx_start_b, tx_start_a);
         check("start_width", prev_start_a, 1'b0);
         log_a.push_back(tx_data_a);
         log_b.push_back(tx_data_b);
         cyc_a.push_back(cyc);
      end
      prev_start_a = tx_start_a;
   end

   task automatic clear_logs();
      log_a.delete();
      log_b.delete();
      cyc_a.delete();
   endtask

   task automatic send(input logic [15:0] v);
      @(negedge clk); #1;
      alu_result  = v;
      send_result = 1'b1;
      req_edge    = cyc + 1;
      @(negedge clk); #1;
      send_result = 1'b0;
      alu_result  = 16'hDEAD;
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k;
      for (k = 0; k < budget && log_a.size() < n; k++) begin
         @(negedge clk); #1;
      end
      if (log_a.size() < n) check("wait_starts_timeout", log_a.size(), n);
   endtask

   task automatic wait_idle(input int budget, output int c);
      c = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (!tx_active_a) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) check("wait_idle_timeout", tx_active_a, 1'b0);
   endtask

   typedef struct {
      logic [15:0] res;
      logic [7:0]  lsb0, lsb1, msb0, msb1;
   } vec_t;

   initial begin
      vec_t vecs[5];
      int   t_idle;
      bit   seen_high, done;
      int   bnd_edge;

      vecs[0] = '{16'hA55A, 8'h5A, 8'hA5, 8'hA5, 8'h5A};
      vecs[1] = '{16'h1234, 8'h34, 8'h12, 8'h12, 8'h34};
      vecs[2] = '{16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      vecs[4] = '{16'h8001, 8'h01, 8'h80, 8'h80, 8'h01};

      reset       = 1'b1;
      send_result = 1'b0;
      alu_result  = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_tx_start", tx_start_a, 1'b0);
      check("rst_tx_data", tx_data_a, 8'h00);
      check("rst_tx_active", tx_active_a, 1'b0);
      check("rst_ack_error", ack_error_a, 1'b0);
      check("rst_tx_data_b", tx_data_b, 8'h00);
      #1 reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         clear_logs();
         send(vecs[i].res);
         wait_idle(100, t_idle);
         check($sformatf("v%0d_nbytes", i), log_a.size(), 2);
         check($sformatf("v%0d_latency", i), cyc_a[0], req_edge);
         check($sformatf("v%0d_lsb_b0", i), log_a[0], vecs[i].lsb0);
         check($sformatf("v%0d_lsb_b1", i), log_a[1], vecs[i].lsb1);
         check($sformatf("v%0d_msb_b0", i), log_b[0], vecs[i].msb0);
         check($sformatf("v%0d_msb_b1", i), log_b[1], vecs[i].msb1);
         check($sformatf("v%0d_gap", i), cyc_a[1] - cyc_a[0], 12);
         check($sformatf("v%0d_idle", i), t_idle - cyc_a[1], 12);
         check($sformatf("v%0d_ack_err", i), {ack_error_a, ack_error_b}, 2'b00);
         repeat (2) @(negedge clk);
      end

      // Back-to-back: 0xBEEF is overwritten by 0xCAFE while pending.
      clear_logs();
      send(16'h1234);
      wait_starts(1, 50);
      repeat (3) @(negedge clk);
      send(16'hBEEF);
      wait_starts(2, 50);
      repeat (3) @(negedge clk);
      send(16'hCAFE);
      wait_idle(200, t_idle);
      check("b2b_nbytes", log_a.size(), 4);
      check("b2b_stream_a", {log_a[0], log_a[1], log_a[2], log_a[3]}, 32'h3412FECA);
      check("b2b_stream_b", {log_b[0], log_b[1], log_b[2], log_b[3]}, 32'h1234CAFE);
      repeat (2) @(negedge clk);

      // Request in the exact cycle busy falls on the last byte.
      clear_logs();
      send(16'h3344);
      wait_starts(2, 50);
      seen_high = 1'b0;
      done      = 1'b0;
      bnd_edge  = -1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk); #1;
         if (tx_busy) seen_high = 1'b1;
         else if (seen_high) begin
            alu_result  = 16'h00FF;
            send_result = 1'b1;
            bnd_edge    = cyc + 1;
            @(negedge clk); #1;
            send_result = 1'b0;
            alu_result  = 16'hDEAD;
            done        = 1'b1;
         end
      end
      check("bnd_found", done, 1'b1);
      wait_idle(200, t_idle);
      check("bnd_nbytes", log_a.size(), 4);
      check("bnd_stream_a", {log_a[0], log_a[1], log_a[2], log_a[3]}, 32'h4433FF00);
      check("bnd_start_cycle", cyc_a[2], bnd_edge);
      check("bnd_gap", cyc_a[2] - cyc_a[1], 12);
      repeat (2) @(negedge clk);

      // Ack timeout with busy tied low.
      busy_mode = 1'b1;
      clear_logs();
      send(16'h0102);
      wait_idle(200, t_idle);
      check("to_nbytes", log_a.size(), 2);
      check("to_stream_a", {log_a[0], log_a[1]}, 16'h0201);
      check("to_stream_b", {log_b[0], log_b[1]}, 16'h0102);
      check("to_gap", cyc_a[1] - cyc_a[0], 17);
      check("to_idle", t_idle - cyc_a[1], 17);
      check("to_ack_error", {ack_error_a, ack_error_b}, 2'b11);
      repeat (20) @(negedge clk);
      check("to_ack_sticky", ack_error_a, 1'b1);
      busy_mode = 1'b0;
      send(16'h5555);
      wait_idle(100, t_idle);
      check("to_ack_sticky_after_send", ack_error_a, 1'b1);
      repeat (2) @(negedge clk);

      // Reset during WAIT_DONE of byte 0 with a request pending.
      clear_logs();
      send(16'h5678);
      wait_starts(1, 50);
      repeat (4) @(negedge clk);
      send(16'h9999);
      @(negedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_outputs_a", {tx_start_a, tx_data_a, tx_active_a, ack_error_a}, 11'h000);
      check("mid_rst_outputs_b", {tx_start_b, tx_data_b, tx_active_b, ack_error_b}, 11'h000);
      @(negedge clk); #1;
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("mid_rst_no_start", log_a.size(), 1);
      check("mid_rst_pending_dropped", tx_active_a, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

endmodule

// File: doc/tx_controller.md
# tx_controller

Downstream neighbour of the receive-side controller in the UART ALU calculator. On a one-cycle `send_result` pulse it captures the 16-bit ALU result and serialises it as two bytes to the UART transmitter through a start/busy handshake. It also holds one pending request so that a result arriving mid-transmission is not lost.

## Interface
Parameters:
- `MSB_FIRST`, default 0: 0 sends the low byte then the high byte; 1 reverses the order.
- `ACK_TIMEOUT`, default 16: maximum cycles to wait for `tx_busy` to rise after `tx_start`. Legal range is 2..255.

Ports:
- `clk`  in  1: system clock. The block uses one clock only.
- `reset`  in  1: synchronous, active-high reset.
- `send_result`  in  1: one-cycle request pulse from the receive controller.
- `alu_result`  in  16: ALU output. It is valid in the cycle `send_result` is high.
- `tx_busy`  in  1: UART transmitter busy. It rises at least 1 cycle after `tx_start` and falls when the byte is done.
- `tx_start`  out  1: one-cycle pulse that launches the byte on `tx_data`.
- `tx_data`  out  8: byte to transmit. It is stable from the `tx_start` cycle until the next `tx_start`.
- `tx_active`  out  1: high while any byte of a result is in flight or pending.
- `ack_error`  out  1: sticky flag, set when the `ACK_TIMEOUT` limit expires. It is cleared only by `reset`.

## Operation
- Registers:
  - `result_q[15:0]`
  - `pending_q[15:0]` and `pending_valid`
  - `byte_idx` (1 bit)
  - timeout counter (8 bits)
- States:
  - `IDLE`: if `send_result` is high, load `result_q ← alu_result`, clear `byte_idx`, go to `START`.
  - `START`: drive `tx_start=1` and set `tx_data` to the selected byte. Go to `WAIT_ACK` and clear the counter.
  - `WAIT_ACK`: if `tx_busy` is high, go to `WAIT_DONE`.
    - Otherwise increment the counter.
    - When the counter reaches `ACK_TIMEOUT-1`, set `ack_error` and treat the byte as sent, i.e. take the `WAIT_DONE` exit path directly.
  - `WAIT_DONE`: when `tx_busy` is low, do the following:
    - If `byte_idx==0`, set `byte_idx ← 1` and go to `START`.
    - Otherwise, if `pending_valid` is set, load `result_q ← pending_q`, clear `pending_valid` and `byte_idx`, and go to `START`.
    - Otherwise go to `IDLE`.
- Byte select:
  - With `MSB_FIRST=0`: byte 0 is `result_q[7:0]` and byte 1 is `result_q[15:8]`.
  - With `MSB_FIRST=1`: the order is swapped.
- `send_result` arriving in any state other than `IDLE`:
  - Load `pending_q ← alu_result` and set `pending_valid`.
  - A second request while one is already pending overwrites `pending_q`: the newest value wins and the pending queue stays one deep.
- `send_result` in the same cycle as the final `WAIT_DONE` exit: the new value is captured into `pending_q` and is sent next. It is never dropped.
- `tx_active` = (state ≠ `IDLE`) OR `pending_valid`. It is registered from the next-state logic.
- Undefined state encodings return to `IDLE`.

## Timing
- Reset values:
  - state `IDLE`
  - `tx_start` 0
  - `tx_data` 0x00
  - `tx_active` 0
  - `ack_error` 0
  - `pending_valid` 0
  - `result_q` and `pending_q` 0
- Reset asserted mid-transmission:
  - Everything aborts on the next edge. No further `tx_start` is issued.
  - Any pending request is discarded.
- Latency:
  - `send_result` sampled at edge N puts `tx_start` high in cycle N+1 for the first byte.
  - The second `tx_start` comes 1 cycle after `tx_busy` is first sampled low in `WAIT_DONE`.
- Outputs:
  - `tx_start` is exactly one cycle wide and is never asserted while in `WAIT_ACK` or `WAIT_DONE`.
  - `tx_data` is registered and changes only on the edge that enters `START`.
- Stuck `tx_busy`: if `tx_busy` stays high, the block waits in `WAIT_DONE` indefinitely. There is no timeout there; only the ack phase is timed.

## Structure
- Shared package `uart_alu_pkg` holds:
  - the 4-bit state constants (`TX_IDLE`, `TX_START`, `TX_WAIT_ACK`, `TX_WAIT_DONE`)
  - `RESULT_W=16` and `BYTE_W=8`, which are also used by the receive controller and the ALU.
- No sub-module is used.
- The block is a single FSM plus datapath registers, about 150–200 lines.

## Test plan
- Basic send:
  - Stimulus: pulse `send_result` with `alu_result`=0xA55A; the transmitter model raises `tx_busy` 1 cycle after `tx_start` and holds it 10 cycles.
  - Required: `tx_start` at N+1 with `tx_data`=0x5A, then a second `tx_start` with 0xA5. `tx_active` falls after the second `busy` drop.
- `MSB_FIRST=1`, same stimulus: byte order is 0xA5 then 0x5A.
- Back-to-back requests:
  - Stimulus: 0x1234, then 0xBEEF during the first byte, then 0xCAFE during the second byte.
  - Required: byte stream 0x34 0x12 0xFE 0xCA. 0xBEEF is overwritten and never sent.
- Boundary request: `send_result` with 0x00FF in the exact cycle `tx_busy` falls on the last byte. Required: 0xFF then 0x00 follow with no gap beyond 1 cycle.
- Ack timeout:
  - Stimulus: `tx_busy` tied low; send 0x0102.
  - Required: two `tx_start` pulses spaced `ACK_TIMEOUT`+1 cycles apart. `ack_error`=1 and stays set until reset.
- Reset mid-operation:
  - Stimulus: assert `reset` during `WAIT_DONE` of byte 0.
  - Required: all outputs go to their reset values on the next edge, with no further `tx_start`.
